// File: rtl/drum_voice_arbiter.sv
// Round-robin arbiter that shares one sample player among the sequencer's drum tracks.
// Trigger rising edges are queued as pending hits and issued one at a time over a start/busy handshake.
module drum_voice_arbiter #(
  parameter int NUM_VOICES  = 5,
  parameter int SEL_W       = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [NUM_VOICES-1:0] Req,
  input  logic                  Player_busy,
  output logic                  Player_start,
  output logic [SEL_W-1:0]      Player_sel,
  output logic [NUM_VOICES-1:0] Grant,
  output logic [NUM_VOICES-1:0] Pending,
  output logic [7:0]            Drop_count,
  output logic                  Timeout,
  output logic [1:0]            state
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    PLAY     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_VOICES-1:0] req_q;
  logic [NUM_VOICES-1:0] pending_q, pending_d;
  logic [NUM_VOICES-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [7:0]            drop_q, drop_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_VOICES-1:0] rise;
  logic [NUM_VOICES-1:0] clear;
  logic [NUM_VOICES-1:0] drops;
  logic                  pick_found;
  logic [SEL_W-1:0]      pick_idx;
  logic [SEL_W-1:0]      cand;

  assign rise = Req & ~req_q;

  // Search starts one past the last granted voice so every track gets its turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_VOICES; k++) begin
      cand = SEL_W'((int'(ptr_q) + k) % NUM_VOICES);
      if (!pick_found && pending_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    clear     = '0;
    pending_d = '0;
    drops     = '0;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (Enable && pick_found) begin
          state_d = ISSUE;
          ptr_d   = pick_idx;
          sel_d   = pick_idx;
          grant_d = NUM_VOICES'(1) << pick_idx;
          clear   = NUM_VOICES'(1) << pick_idx;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        timer_d = '0;
      end
      WAIT_ACK: begin
        if (Player_busy) begin
          state_d = PLAY;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          grant_d   = '0;
          sel_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PLAY: begin
        if (!Player_busy) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A rise landing on the very edge its voice is granted re-queues instead of dropping.
    if (Enable) begin
      pending_d = (pending_q & ~clear) | rise;
      drops     = rise & pending_q & ~clear;
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (drops[i] && drop_d != 8'hFF) begin
        drop_d = drop_d + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_VOICES - 1);
      timer_q   <= '0;
      drop_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= Req;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      drop_q    <= drop_d;
      timeout_q <= timeout_d;
    end
  end

  assign Player_start = (state_q == ISSUE);
  assign Player_sel   = sel_q;
  assign Grant        = grant_q;
  assign Pending      = pending_q;
  assign Drop_count   = drop_q;
  assign Timeout      = timeout_q;
  assign state        = state_q;

endmodule
